// File: rtl/spi_readback.sv
// spi_readback: SPI slave read path; decodes {rw, addr} and shifts register data MSB-first onto poci.
// Latency: first data bit valid after rising edge DATA_W+1 of the frame; no backpressure, spi_clk paces all.
module spi_readback #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int AUTO_INC = 1
) (
  input  logic              spi_clk,
  input  logic              rstn,
  inout  wire               DVDD,
  inout  wire               DVSS,
  input  logic              cs,
  input  logic              pico,
  input  logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  output logic              poci,
  output logic              poci_oe
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W - 1);

  localparam logic [1:0] ST_CMD    = 2'd0;
  localparam logic [1:0] ST_READ   = 2'd1;
  localparam logic [1:0] ST_IGNORE = 2'd2;

  logic [1:0]        state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] cmd_byte;
  logic              last_bit;
  logic              rst_n_i;

  // Supply pins only pass through to the pads.
  wire unused_supply = DVDD ^ DVSS;

  // Deasserting cs tears the whole frame down immediately.
  assign rst_n_i  = rstn & ~cs;
  assign last_bit = (bit_cnt == CNT_MAX);
  assign cmd_byte = {shreg[DATA_W-2:0], pico};

  always_ff @(posedge spi_clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= ST_CMD;
      bit_cnt <= '0;
      shreg   <= '0;
      rd_addr <= '0;
      rd_en   <= 1'b0;
      poci    <= 1'b0;
      poci_oe <= 1'b0;
    end else begin
      bit_cnt <= last_bit ? '0 : bit_cnt + CNT_W'(1);
      case (state)
        ST_CMD: begin
          shreg <= cmd_byte;
          if (last_bit) begin
            if (!cmd_byte[DATA_W-1]) begin
              rd_addr <= cmd_byte[ADDR_W-1:0];
              rd_en   <= 1'b1;
              state   <= ST_READ;
            end else begin
              state   <= ST_IGNORE;
            end
          end
        end
        ST_READ: begin
          // shreg holds the bits still to be sent, left-aligned.
          if (bit_cnt == '0) begin
            shreg   <= {rdata[DATA_W-2:0], 1'b0};
            poci    <= rdata[DATA_W-1];
            poci_oe <= 1'b1;
            rd_en   <= 1'b0;
          end else begin
            shreg   <= {shreg[DATA_W-2:0], 1'b0};
            poci    <= shreg[DATA_W-1];
          end
          if (last_bit) begin
            if (AUTO_INC != 0) rd_addr <= rd_addr + ADDR_W'(1);
            rd_en <= 1'b1;
          end
        end
        default: begin
          poci    <= 1'b0;
          poci_oe <= 1'b0;
          rd_en   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_readback.sv
// Directed bench for spi_readback: reset, single read, wrapping burst, write, short command, abort, no-increment burst.
`timescale 1ns/1ps
module tb_spi_readback;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  logic              spi_clk = 1'b0;
  logic              rstn = 1'b0;
  logic              cs = 1'b1;
  logic              pico = 1'b0;
  wire               dvdd = 1'b1;
  wire               dvss = 1'b0;
  logic [DATA_W-1:0] rdata, rdata2;
  logic [ADDR_W-1:0] rd_addr, rd_addr2;
  logic              rd_en, rd_en2, poci, poci2, poci_oe, poci_oe2;
  logic              use_fixed = 1'b1;
  logic [7:0]        fixed_dat = 8'h00;

  int compared = 0;
  int mismatched = 0;
  int en_cnt = 0;
  int en_cnt2 = 0;

  always #10 spi_clk = ~spi_clk;

  // Register-file model: fixed byte, or the address inverted.
  assign rdata  = use_fixed ? fixed_dat : ({1'b0, rd_addr}  ^ 8'hFF);
  assign rdata2 = use_fixed ? fixed_dat : ({1'b0, rd_addr2} ^ 8'hFF);

  spi_readback #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .AUTO_INC(1)) dut (
    .spi_clk(spi_clk), .rstn(rstn), .DVDD(dvdd), .DVSS(dvss), .cs(cs), .pico(pico),
    .rdata(rdata), .rd_addr(rd_addr), .rd_en(rd_en), .poci(poci), .poci_oe(poci_oe)
  );

  spi_readback #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .AUTO_INC(0)) dut_noinc (
    .spi_clk(spi_clk), .rstn(rstn), .DVDD(dvdd), .DVSS(dvss), .cs(cs), .pico(pico),
    .rdata(rdata2), .rd_addr(rd_addr2), .rd_en(rd_en2), .poci(poci2), .poci_oe(poci_oe2)
  );

  // rd_en lasts one spi_clk cycle, so one low-phase sample per pulse.
  always @(negedge spi_clk) begin
    if (rd_en === 1'b1) en_cnt++;
    if (rd_en2 === 1'b1) en_cnt2++;
  end

  task automatic step(input logic p);
    #2 pico = p;
    @(negedge spi_clk);
  endtask

  task automatic frame_start();
    @(negedge spi_clk);
    #1 cs = 1'b0;
    en_cnt = 0;
    en_cnt2 = 0;
  endtask

  task automatic frame_end();
    #1 cs = 1'b1;
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] c);
    for (int i = 0; i < 8; i++) step(c[7-i]);
  endtask

  task automatic test_reset();
    rstn = 1'b0; cs = 1'b0; pico = 1'b1; en_cnt = 0;
    repeat (6) @(negedge spi_clk);
    compared++; if (poci !== 1'b0) begin mismatched++; $display("FAIL reset_poci: got %b want 0", poci); end
    compared++; if (poci_oe !== 1'b0) begin mismatched++; $display("FAIL reset_poci_oe: got %b want 0", poci_oe); end
    compared++; if (rd_addr !== 7'h00) begin mismatched++; $display("FAIL reset_rd_addr: got %h want 00", rd_addr); end
    compared++; if (en_cnt != 0) begin mismatched++; $display("FAIL reset_rd_en_pulses: got %0d want 0", en_cnt); end
    #1 rstn = 1'b1; cs = 1'b1;
  endtask

  task automatic test_single_read();
    logic [7:0] exp;
    exp = 8'hA5;
    use_fixed = 1'b1; fixed_dat = 8'hA5;
    frame_start();
    send_cmd(8'h05);
    compared++; if (rd_addr !== 7'h05) begin mismatched++; $display("FAIL single_addr: got %h want 05", rd_addr); end
    compared++; if (rd_en !== 1'b1) begin mismatched++; $display("FAIL single_rd_en_decode: got %b want 1", rd_en); end
    compared++; if (poci_oe !== 1'b0) begin mismatched++; $display("FAIL single_oe_early: got %b want 0", poci_oe); end
    for (int i = 0; i < 8; i++) begin
      step(1'b0);
      compared++; if (poci !== exp[7-i]) begin mismatched++; $display("FAIL single_bit%0d: got %b want %b", 7-i, poci, exp[7-i]); end
      compared++; if (poci_oe !== 1'b1) begin mismatched++; $display("FAIL single_oe_edge%0d: got %b want 1", 9+i, poci_oe); end
      if (i == 0) begin
        compared++; if (rd_en !== 1'b0) begin mismatched++; $display("FAIL single_rd_en_load: got %b want 0", rd_en); end
      end
    end
    compared++; if (rd_en !== 1'b1) begin mismatched++; $display("FAIL single_rd_en_done: got %b want 1", rd_en); end
    compared++; if (rd_addr !== 7'h06) begin mismatched++; $display("FAIL single_addr_inc: got %h want 06", rd_addr); end
    frame_end();
    compared++; if (poci_oe !== 1'b0) begin mismatched++; $display("FAIL single_oe_cs: got %b want 0", poci_oe); end
    compared++; if (rd_en !== 1'b0) begin mismatched++; $display("FAIL single_rd_en_cs: got %b want 0", rd_en); end
    compared++; if (rd_addr !== 7'h00) begin mismatched++; $display("FAIL single_addr_cs: got %h want 00", rd_addr); end
    compared++; if (en_cnt != 2) begin mismatched++; $display("FAIL single_pulses: got %0d want 2", en_cnt); end
  endtask

  task automatic test_burst_wrap();
    logic [7:0]        exp_b [3];
    logic [ADDR_W-1:0] exp_a [3];
    logic [7:0]        got;
    exp_b[0] = 8'h80; exp_b[1] = 8'hFF; exp_b[2] = 8'hFE;
    exp_a[0] = 7'h00; exp_a[1] = 7'h01; exp_a[2] = 7'h02;
    use_fixed = 1'b0;
    frame_start();
    send_cmd(8'h7F);
    compared++; if (rd_addr !== 7'h7F) begin mismatched++; $display("FAIL burst_addr0: got %h want 7f", rd_addr); end
    for (int b = 0; b < 3; b++) begin
      got = 8'h00;
      for (int i = 0; i < 8; i++) begin
        step(1'b0);
        got = {got[6:0], poci};
      end
      compared++; if (got !== exp_b[b]) begin mismatched++; $display("FAIL burst_byte%0d: got %h want %h", b, got, exp_b[b]); end
      compared++; if (rd_addr !== exp_a[b]) begin mismatched++; $display("FAIL burst_addr%0d: got %h want %h", b+1, rd_addr, exp_a[b]); end
    end
    frame_end();
    compared++; if (en_cnt != 4) begin mismatched++; $display("FAIL burst_pulses: got %0d want 4", en_cnt); end
  endtask

  task automatic test_write();
    logic [15:0] w;
    logic        any_oe, any_poci;
    w = 16'h835A; any_oe = 1'b0; any_poci = 1'b0;
    use_fixed = 1'b1; fixed_dat = 8'hFF;
    frame_start();
    for (int i = 0; i < 16; i++) begin
      step(w[15-i]);
      any_oe   = any_oe | poci_oe;
      any_poci = any_poci | poci;
    end
    compared++; if (any_oe !== 1'b0) begin mismatched++; $display("FAIL write_oe: got %b want 0", any_oe); end
    compared++; if (any_poci !== 1'b0) begin mismatched++; $display("FAIL write_poci: got %b want 0", any_poci); end
    compared++; if (rd_addr !== 7'h00) begin mismatched++; $display("FAIL write_addr: got %h want 00", rd_addr); end
    frame_end();
    compared++; if (en_cnt != 0) begin mismatched++; $display("FAIL write_pulses: got %0d want 0", en_cnt); end
  endtask

  task automatic test_short_cmd();
    use_fixed = 1'b1; fixed_dat = 8'hA5;
    frame_start();
    for (int i = 0; i < 5; i++) step(1'b0);
    frame_end();
    compared++; if (en_cnt != 0) begin mismatched++; $display("FAIL short_pulses: got %0d want 0", en_cnt); end
    compared++; if (poci_oe !== 1'b0) begin mismatched++; $display("FAIL short_oe: got %b want 0", poci_oe); end
  endtask

  task automatic test_abort();
    logic [7:0] got;
    use_fixed = 1'b0;
    frame_start();
    send_cmd(8'h10);
    for (int i = 0; i < 4; i++) step(1'b0);
    compared++; if (poci !== 1'b0) begin mismatched++; $display("FAIL abort_bit4: got %b want 0", poci); end
    compared++; if (poci_oe !== 1'b1) begin mismatched++; $display("FAIL abort_oe_mid: got %b want 1", poci_oe); end
    frame_end();
    compared++; if (rd_addr !== 7'h00) begin mismatched++; $display("FAIL abort_addr_clr: got %h want 00", rd_addr); end
    compared++; if (poci_oe !== 1'b0) begin mismatched++; $display("FAIL abort_oe_clr: got %b want 0", poci_oe); end
    frame_start();
    send_cmd(8'h20);
    compared++; if (rd_addr !== 7'h20) begin mismatched++; $display("FAIL abort_addr2: got %h want 20", rd_addr); end
    got = 8'h00;
    for (int i = 0; i < 8; i++) begin
      step(1'b0);
      got = {got[6:0], poci};
    end
    compared++; if (got !== 8'hDF) begin mismatched++; $display("FAIL abort_byte2: got %h want df", got); end
    frame_end();
  endtask

  task automatic test_no_inc();
    logic [7:0] got;
    use_fixed = 1'b0;
    frame_start();
    send_cmd(8'h03);
    for (int b = 0; b < 2; b++) begin
      got = 8'h00;
      for (int i = 0; i < 8; i++) begin
        step(1'b0);
        got = {got[6:0], poci2};
      end
      compared++; if (got !== 8'hFC) begin mismatched++; $display("FAIL noinc_byte%0d: got %h want fc", b, got); end
      compared++; if (rd_addr2 !== 7'h03) begin mismatched++; $display("FAIL noinc_addr%0d: got %h want 03", b, rd_addr2); end
    end
    frame_end();
    compared++; if (en_cnt2 != 3) begin mismatched++; $display("FAIL noinc_pulses: got %0d want 3", en_cnt2); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", compared);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_read();
    test_burst_wrap();
    test_write();
    test_short_cmd();
    test_abort();
    test_no_inc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/spi_readback.md
Name: spi_readback

Overview:
- Read-direction half of the SPI slave: decodes the command byte from the controller and, for read commands, serializes register data MSB-first onto poci.
- Sits beside spi_frontend on the same pads (spi_clk, pico, cs, rstn).
- Drives a read address into the register file and shifts back the returned byte.
- Supports burst reads with address auto-increment while cs stays low.

Parameters:
- ADDR_W, 7, command/register address width; command byte = {rw, addr[ADDR_W-1:0]}.
- DATA_W, 8, register data width and bits per data byte.
- AUTO_INC, 1, 1 = increment rd_addr after each data byte in a burst; 0 = re-read the same address.

Ports:
- spi_clk  input  1  SPI clock from pad; all flops rising-edge.
- rstn  input  1  asynchronous active-low reset.
- DVDD  inout  1  local digital supply.
- DVSS  inout  1  local digital ground.
- cs  input  1  chip select, active low; cs high asynchronously clears frame state.
- pico  input  1  serial data from controller, sampled on spi_clk rising edge.
- rdata  input  DATA_W  register-file read data for rd_addr.
- rd_addr  output  ADDR_W  read address to register file.
- rd_en  output  1  one-cycle read strobe, for clear-on-read registers.
- poci  output  1  serial data to controller.
- poci_oe  output  1  pad output enable; 1 only while a read byte is shifting.

Behaviour:
- Internal reset rst_i = !rstn | cs, applied asynchronously to all flops.
- Reset values: poci=0, poci_oe=0, rd_en=0, rd_addr=0, bit_cnt=0, state=CMD, shift register=0.
- bit_cnt: 0..DATA_W-1, increments every spi_clk rising edge, wraps to 0 after DATA_W-1.
- CMD state:
  - Shift pico in MSB-first.
  - At the edge where bit_cnt==7, the complete byte is {shreg[6:0], pico}.
  - If bit7==0 (read): rd_addr <= byte[6:0], rd_en <= 1, state -> READ.
  - If bit7==1 (write): state -> IGNORE.
- READ state:
  - At the edge with bit_cnt==0: load shift-out register from rdata, poci <= rdata[7], poci_oe <= 1, rd_en <= 0.
  - Edges with bit_cnt==1..7: shift left, poci <= next bit (bit6..bit0).
  - Controller samples poci on the falling edge following each rising edge.
  - Timing: data bit7 valid after rising edge 9 of the frame; bit0 after edge 16.
  - rdata must be stable within one spi_clk period of rd_addr changing.
  - Byte complete (edge with bit_cnt==7): if AUTO_INC, rd_addr <= rd_addr+1 mod 2^ADDR_W (127 wraps to 0); rd_en <= 1. Next byte loads at the following edge.
  - pico is ignored in READ.
- IGNORE state:
  - poci_oe=0, poci=0, rd_en=0 until cs rises; pico ignored (handled by spi_frontend).
- Boundary cases:
  - cs rising mid-byte: immediate async clear; partial byte discarded; no rd_addr increment.
  - rstn low mid-frame: same as cs rising.
  - Next frame always starts in CMD with bit_cnt=0.
  - Frame ending exactly on a byte boundary: the increment already applied is discarded by the reset.
  - Fewer than 8 command bits: no read issued, rd_en never asserts.
- rd_en asserts once per byte read: first at command decode, then at each byte completion, including the final one. It is deasserted by the load edge or by cs rising.

Test Plan:
- Reset: rstn=0, cs=0, clock toggling -> all outputs 0, rd_en never pulses.
- Single read: cmd 0x05, rdata=0xA5 -> rd_addr=0x05 after edge 8; rd_en high between edges 8 and 9; poci bits 1,0,1,0,0,1,0,1 after edges 9..16; poci_oe=1 over edges 9..16; cs high -> poci_oe=0.
- Burst with wrap: cmd 0x7F, 3 data bytes, regfile model returns addr^0xFF -> poci bytes 0x80, 0xFF, 0xFE; rd_addr sequence 0x7F, 0x00, 0x01, 0x02.
- Write command: cmd 0x83 followed by 0x5A -> poci_oe=0 throughout, rd_en never asserts, rd_addr unchanged at 0.
- Abort: cs rises after 4 data bits of a read from 0x10, then new read cmd 0x20 -> second frame returns rdata(0x20) from bit7, no stale bits; rd_addr=0x20.
- AUTO_INC=0 burst: cmd 0x03, 2 data bytes -> both bytes come from addr 0x03; rd_en pulses 3 times.
